// File: rtl/spi_cmd_decoder_if.sv
// Bundle between the SPI receive stage and the command decoder, plus the
// decoder's register-bus outputs and a debug view of its FSM state.
interface spi_cmd_decoder_if #(
   parameter int WIDTH = 8
);
   // Handshake: byte_ready is a level from the sclk domain. A byte is offered
   // on its rising edge, and command_byte must hold until byte_ready falls.
   // There is no backpressure: an offered byte is either decoded or dropped.
   // The register-side strobes (reg_wr_en/reg_rd_en) are one-clk valid
   // pulses, and reg_addr/reg_wr_data are qualified by them.
   logic             cs;
   logic [WIDTH-1:0] command_byte;
   logic             byte_ready;
   logic [WIDTH-1:0] reg_addr;
   logic [WIDTH-1:0] reg_wr_data;
   logic             reg_wr_en;
   logic             reg_rd_en;
   logic             frame_error;
   logic [7:0]       cmd_count;
   logic [7:0]       err_count;
   logic [1:0]       dbg_state;

   modport master (
      output cs, command_byte, byte_ready,
      input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, frame_error,
             cmd_count, err_count, dbg_state
   );

   modport slave (
      input  cs, command_byte, byte_ready,
      output reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, frame_error,
             cmd_count, err_count, dbg_state
   );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Decodes WRITE/READ/NOP command frames delivered byte-wise by an SPI
// receive stage into one-clk register strobes, and counts commands and errors.
module spi_cmd_decoder #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   spi_cmd_decoder_if.slave    bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GET_ADDR = 2'd1,
      GET_DATA = 2'd2,
      DISCARD  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] OP_NOP   = WIDTH'(0);
   localparam logic [WIDTH-1:0] OP_WRITE = WIDTH'(1);
   localparam logic [WIDTH-1:0] OP_READ  = WIDTH'(2);

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_br_sync;
   logic                   r_br_prev;
   state_t                 r_state;
   logic                   r_is_write;
   logic [WIDTH-1:0]       r_addr;
   logic [WIDTH-1:0]       r_wr_data;
   logic                   r_wr_en;
   logic                   r_rd_en;
   logic                   r_frame_error;
   logic [7:0]             r_cmd_count;
   logic [7:0]             r_err_count;

   logic                   w_cs_s;
   logic                   w_strobe;
   state_t                 w_next;
   logic                   w_op_ld;
   logic                   w_ld_addr;
   logic                   w_ld_data;
   logic                   w_wr;
   logic                   w_rd;
   logic                   w_err;

   // cs synchronizer idles at 1 so a reset looks like a deselected bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cs_sync <= '1;
         r_br_sync <= '0;
         r_br_prev <= 1'b0;
      end else begin
         r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
         r_br_sync <= {r_br_sync[SYNC_STAGES-2:0], bus.byte_ready};
         r_br_prev <= r_br_sync[SYNC_STAGES-1];
      end
   end

   assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
   assign w_strobe = r_br_sync[SYNC_STAGES-1] & ~r_br_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Deselect outranks a simultaneous strobe, so an in-flight byte is dropped.
   always_comb begin
      w_next    = r_state;
      w_op_ld   = 1'b0;
      w_ld_addr = 1'b0;
      w_ld_data = 1'b0;
      w_wr      = 1'b0;
      w_rd      = 1'b0;
      w_err     = 1'b0;
      if (w_cs_s) begin
         w_next = IDLE;
         if (r_state == GET_ADDR || r_state == GET_DATA) w_err = 1'b1;
      end else if (w_strobe) begin
         case (r_state)
            IDLE: begin
               if (bus.command_byte == OP_WRITE || bus.command_byte == OP_READ) begin
                  w_op_ld = 1'b1;
                  w_next  = GET_ADDR;
               end else if (bus.command_byte != OP_NOP) begin
                  w_err  = 1'b1;
                  w_next = DISCARD;
               end
            end
            GET_ADDR: begin
               w_ld_addr = 1'b1;
               if (r_is_write) begin
                  w_next = GET_DATA;
               end else begin
                  w_rd   = 1'b1;
                  w_next = IDLE;
               end
            end
            GET_DATA: begin
               w_ld_data = 1'b1;
               w_wr      = 1'b1;
               w_next    = IDLE;
            end
            default: w_next = DISCARD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_write    <= 1'b0;
         r_addr        <= '0;
         r_wr_data     <= '0;
         r_wr_en       <= 1'b0;
         r_rd_en       <= 1'b0;
         r_frame_error <= 1'b0;
         r_cmd_count   <= 8'd0;
         r_err_count   <= 8'd0;
      end else begin
         r_wr_en       <= w_wr;
         r_rd_en       <= w_rd;
         r_frame_error <= w_err;
         if (w_op_ld)   r_is_write <= (bus.command_byte == OP_WRITE);
         if (w_ld_addr) r_addr     <= bus.command_byte;
         if (w_ld_data) r_wr_data  <= bus.command_byte;
         if (w_wr || w_rd) r_cmd_count <= r_cmd_count + 8'd1;
         if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
   end

   assign bus.reg_addr    = r_addr;
   assign bus.reg_wr_data = r_wr_data;
   assign bus.reg_wr_en   = r_wr_en;
   assign bus.reg_rd_en   = r_rd_en;
   assign bus.frame_error = r_frame_error;
   assign bus.cmd_count   = r_cmd_count;
   assign bus.err_count   = r_err_count;
   assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: expected strobes go into a queue as
// bytes are sent; a monitor pops and compares every pulse the DUT emits.
module tb_spi_cmd_decoder;
   localparam int W = 19;  // {wr, rd, err, addr, data}

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [W-1:0] exp_q[$];

   spi_cmd_decoder_if #(.WIDTH(8)) bus();

   spi_cmd_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] ev(input logic wr, input logic rd, input logic err,
                                       input logic [7:0] a, input logic [7:0] d);
      return {wr, rd, err, a, d};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [W-1:0] act;
      logic [W-1:0] e;
      if (!rst && (bus.reg_wr_en || bus.reg_rd_en || bus.frame_error)) begin
         act = {bus.reg_wr_en, bus.reg_rd_en, bus.frame_error,
                (bus.reg_wr_en || bus.reg_rd_en) ? bus.reg_addr : 8'h00,
                bus.reg_wr_en ? bus.reg_wr_data : 8'h00};
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got %h expected none", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL pulse: got %h expected %h", act, e);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.command_byte = b;
      bus.byte_ready   = 1'b1;
      repeat (4) @(negedge clk);
      bus.byte_ready   = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_low();
      @(negedge clk);
      bus.cs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      @(negedge clk);
      bus.cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_addr"},  bus.reg_addr, 0);
      chk({tag, "_wdata"}, bus.reg_wr_data, 0);
      chk({tag, "_flags"}, {bus.reg_wr_en, bus.reg_rd_en, bus.frame_error}, 0);
      chk({tag, "_cmd"},   bus.cmd_count, 0);
      chk({tag, "_err"},   bus.err_count, 0);
      chk({tag, "_state"}, bus.dbg_state, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.cs           = 1'b1;
      bus.command_byte = 8'h00;
      bus.byte_ready   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("init");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single write
      cs_low();
      send_byte(8'h01);
      send_byte(8'h10);
      exp_q.push_back(ev(1, 0, 0, 8'h10, 8'hA5));
      send_byte(8'hA5);
      cs_high();
      chk("write_cmd_count", bus.cmd_count, 1);
      chk("write_addr_hold", bus.reg_addr, 8'h10);

      // Single read
      cs_low();
      send_byte(8'h02);
      exp_q.push_back(ev(0, 1, 0, 8'h33, 8'h00));
      send_byte(8'h33);
      cs_high();
      chk("read_cmd_count", bus.cmd_count, 2);

      // Bad opcode then the rest of the frame is discarded
      cs_low();
      exp_q.push_back(ev(0, 0, 1, 8'h00, 8'h00));
      send_byte(8'h7F);
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h55);
      chk("discard_state", bus.dbg_state, 3);
      cs_high();
      chk("bad_op_err_count", bus.err_count, 1);
      chk("bad_op_cmd_count", bus.cmd_count, 2);
      cs_low();
      send_byte(8'h02);
      exp_q.push_back(ev(0, 1, 0, 8'h44, 8'h00));
      send_byte(8'h44);
      cs_high();
      chk("after_discard_cmd_count", bus.cmd_count, 3);

      // Truncated write aborted by cs
      cs_low();
      send_byte(8'h01);
      send_byte(8'h20);
      chk("trunc_state_get_data", bus.dbg_state, 2);
      exp_q.push_back(ev(0, 0, 1, 8'h00, 8'h00));
      cs_high();
      chk("trunc_state_idle", bus.dbg_state, 0);
      chk("trunc_err_count", bus.err_count, 2);
      chk("trunc_addr_loaded", bus.reg_addr, 8'h20);

      // Back-to-back commands and a NOP in one frame
      cs_low();
      send_byte(8'h01);
      send_byte(8'h05);
      exp_q.push_back(ev(1, 0, 0, 8'h05, 8'h06));
      send_byte(8'h06);
      send_byte(8'h00);
      send_byte(8'h02);
      exp_q.push_back(ev(0, 1, 0, 8'h07, 8'h00));
      send_byte(8'h07);
      cs_high();
      chk("b2b_cmd_count", bus.cmd_count, 5);
      chk("b2b_err_count", bus.err_count, 2);
      chk("b2b_wdata_hold", bus.reg_wr_data, 8'h06);

      // Reset mid-frame: partial write discarded, no error
      cs_low();
      send_byte(8'h01);
      send_byte(8'h40);
      pulse_reset();
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(8'h02);
      exp_q.push_back(ev(0, 1, 0, 8'h08, 8'h00));
      send_byte(8'h08);
      cs_high();
      chk("post_rst_cmd_count", bus.cmd_count, 1);
      chk("post_rst_err_count", bus.err_count, 0);

      // cmd_count wrap
      pulse_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      cs_low();
      for (int i = 0; i < 256; i++) begin
         send_byte(8'h02);
         exp_q.push_back(ev(0, 1, 0, 8'(i), 8'h00));
         send_byte(8'(i));
         if (i == 254) chk("cmd_count_255", bus.cmd_count, 255);
      end
      cs_high();
      chk("cmd_count_wrap", bus.cmd_count, 0);

      // err_count saturation
      for (int i = 0; i < 300; i++) begin
         cs_low();
         exp_q.push_back(ev(0, 0, 1, 8'h00, 8'h00));
         send_byte(8'h10 + 8'(i % 64));
         cs_high();
         if (i == 254) chk("err_count_255", bus.err_count, 255);
      end
      chk("err_count_sat", bus.err_count, 255);
      chk("sat_cmd_count", bus.cmd_count, 0);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
